// File: rtl/cache_mem_arbiter_if.sv
// Line-port bundle between the two L1 caches, the arbiter and physical memory.
// The slave modport is the arbiter; the master modport is the cache/memory side.
interface cache_mem_arbiter_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned LINE_W = 128,
   parameter int unsigned CNT_W  = 16
) ();

   // icache side
   logic              i_read;
   logic [ADDR_W-1:0] i_addr;
   logic [LINE_W-1:0] i_rdata;
   logic              i_resp;

   // dcache side
   logic              d_read;
   logic              d_write;
   logic [ADDR_W-1:0] d_addr;
   logic [LINE_W-1:0] d_wdata;
   logic [LINE_W-1:0] d_rdata;
   logic              d_resp;

   // memory side
   logic              m_read;
   logic              m_write;
   logic [ADDR_W-1:0] m_addr;
   logic [LINE_W-1:0] m_wdata;
   logic [LINE_W-1:0] m_rdata;
   logic              m_resp;

   // monitoring
   logic [CNT_W-1:0]  i_grant_cnt;
   logic [CNT_W-1:0]  d_grant_cnt;
   logic              proto_err;

   modport slave (
      input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, m_rdata, m_resp,
      output i_rdata, i_resp, d_rdata, d_resp, m_read, m_write, m_addr, m_wdata,
      output i_grant_cnt, d_grant_cnt, proto_err
   );

   modport master (
      output i_read, i_addr, d_read, d_write, d_addr, d_wdata, m_rdata, m_resp,
      input  i_rdata, i_resp, d_rdata, d_resp, m_read, m_write, m_addr, m_wdata,
      input  i_grant_cnt, d_grant_cnt, proto_err
   );

endinterface

// File: rtl/cache_mem_arbiter.sv
// Shares the single memory line port between icache and dcache, one transaction at a time.
// Ties go to the dcache (with an anti-starvation escape for the icache) or round-robin.
module cache_mem_arbiter #(
   parameter int unsigned ADDR_W       = 16,
   parameter int unsigned LINE_W       = 128,
   parameter bit          FIXED_DPRIO  = 1'b1,
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned CNT_W        = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   cache_mem_arbiter_if.slave  bus
);

   localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   typedef enum logic [1:0] {StIdle, StServeI, StServeD} state_e;

   state_e            state_q, state_d;
   logic              m_read_q, m_read_d;
   logic              m_write_q, m_write_d;
   logic [ADDR_W-1:0] m_addr_q, m_addr_d;
   logic [LINE_W-1:0] m_wdata_q, m_wdata_d;
   logic [SW-1:0]     starve_q, starve_d;
   logic              last_d_q, last_d_d;   // 1: last grant went to the dcache
   logic              proto_err_q, proto_err_d;
   logic [CNT_W-1:0]  i_cnt_q, i_cnt_d;
   logic [CNT_W-1:0]  d_cnt_q, d_cnt_d;
   logic              req_i, req_d, pick_d;
   logic              i_resp, d_resp;

   // State and latched transaction registers; reset abandons any in-flight transaction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         m_read_q    <= 1'b0;
         m_write_q   <= 1'b0;
         m_addr_q    <= '0;
         m_wdata_q   <= '0;
         starve_q    <= '0;
         last_d_q    <= 1'b0;
         proto_err_q <= 1'b0;
         i_cnt_q     <= '0;
         d_cnt_q     <= '0;
      end else begin
         state_q     <= state_d;
         m_read_q    <= m_read_d;
         m_write_q   <= m_write_d;
         m_addr_q    <= m_addr_d;
         m_wdata_q   <= m_wdata_d;
         starve_q    <= starve_d;
         last_d_q    <= last_d_d;
         proto_err_q <= proto_err_d;
         i_cnt_q     <= i_cnt_d;
         d_cnt_q     <= d_cnt_d;
      end
   end

   // Arbitration in IDLE, completion handling while serving.
   always_comb begin
      state_d     = state_q;
      m_read_d    = m_read_q;
      m_write_d   = m_write_q;
      m_addr_d    = m_addr_q;
      m_wdata_d   = m_wdata_q;
      starve_d    = starve_q;
      last_d_d    = last_d_q;
      proto_err_d = proto_err_q;
      i_cnt_d     = i_cnt_q;
      d_cnt_d     = d_cnt_q;
      i_resp      = 1'b0;
      d_resp      = 1'b0;
      req_i       = bus.i_read;
      req_d       = bus.d_read | bus.d_write;
      pick_d      = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (req_i && req_d) begin
               pick_d = FIXED_DPRIO ? (starve_q != STARVE_MAX) : !last_d_q;
            end else begin
               pick_d = req_d;
            end
            if (req_d && pick_d) begin
               state_d   = StServeD;
               m_addr_d  = bus.d_addr;
               m_wdata_d = bus.d_wdata;
               // A simultaneous read and write is resolved as a write-back.
               m_write_d = bus.d_write;
               m_read_d  = !bus.d_write;
               last_d_d  = 1'b1;
               if (bus.d_read && bus.d_write) begin
                  proto_err_d = 1'b1;
               end
               if (req_i && (starve_q != STARVE_MAX)) begin
                  starve_d = starve_q + SW'(1);
               end
            end else if (req_i) begin
               state_d   = StServeI;
               m_addr_d  = bus.i_addr;
               m_read_d  = 1'b1;
               m_write_d = 1'b0;
               last_d_d  = 1'b0;
               starve_d  = '0;
            end
         end
         StServeI: begin
            if (bus.m_resp) begin
               i_resp    = 1'b1;
               state_d   = StIdle;
               m_read_d  = 1'b0;
               m_write_d = 1'b0;
               if (i_cnt_q != '1) begin
                  i_cnt_d = i_cnt_q + CNT_W'(1);
               end
            end
         end
         StServeD: begin
            if (bus.m_resp) begin
               d_resp    = 1'b1;
               state_d   = StIdle;
               m_read_d  = 1'b0;
               m_write_d = 1'b0;
               if (d_cnt_q != '1) begin
                  d_cnt_d = d_cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign bus.m_read      = m_read_q;
   assign bus.m_write     = m_write_q;
   assign bus.m_addr      = m_addr_q;
   assign bus.m_wdata     = m_wdata_q;
   assign bus.i_resp      = i_resp;
   assign bus.d_resp      = d_resp;
   assign bus.i_rdata     = bus.m_rdata;
   assign bus.d_rdata     = bus.m_rdata;
   assign bus.i_grant_cnt = i_cnt_q;
   assign bus.d_grant_cnt = d_cnt_q;
   assign bus.proto_err   = proto_err_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model (grant choice, counters, sticky error).
module tb_cache_mem_arbiter;

   localparam int unsigned LIMIT = 4;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   cache_mem_arbiter_if #(.ADDR_W(16), .LINE_W(128), .CNT_W(16)) b0 ();
   cache_mem_arbiter_if #(.ADDR_W(16), .LINE_W(128), .CNT_W(2))  b1 ();

   cache_mem_arbiter #(
      .ADDR_W(16), .LINE_W(128), .FIXED_DPRIO(1'b1), .STARVE_LIMIT(LIMIT), .CNT_W(16)
   ) u0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b0)
   );

   cache_mem_arbiter #(
      .ADDR_W(16), .LINE_W(128), .FIXED_DPRIO(1'b0), .STARVE_LIMIT(LIMIT), .CNT_W(2)
   ) u1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model state for u0
   int m_starve;
   bit m_last_d;
   int m_icnt;
   int m_dcnt;
   bit m_perr;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Winner of an IDLE-cycle arbitration for the fixed-priority instance.
   function automatic bit model_pick_d(bit ri, bit rd);
      if (!ri) return rd;
      if (!rd) return 1'b0;
      return m_starve != LIMIT;
   endfunction

   task automatic model_grant(input bit ri, input bit gd);
      if (gd) begin
         if (ri) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
         m_dcnt++;
      end else begin
         m_starve = 0;
         m_icnt++;
      end
      m_last_d = gd;
   endtask

   // Called at a negedge with requests applied; serves one transaction on u0 with lat
   // wait cycles before m_resp. Scrambles the cache-side address/data after the grant.
   task automatic txn0(input int lat, output logic rd, output logic wr, output logic [15:0] addr,
                       output logic [127:0] wdata, output int hi, output logic ir,
                       output logic dr, output logic [127:0] irdata,
                       output logic [127:0] drdata, output logic [127:0] mrd);
      @(negedge clk);
      #1;
      rd = b0.m_read; wr = b0.m_write; addr = b0.m_addr; wdata = b0.m_wdata; hi = 0;
      b0.i_addr  = 16'($urandom);
      b0.d_addr  = 16'($urandom);
      b0.d_wdata = {$urandom, $urandom, $urandom, $urandom};
      for (int c = 0; c < lat; c++) begin
         if ((rd | wr) && b0.m_read === rd && b0.m_write === wr && b0.m_addr === addr &&
             b0.m_wdata === wdata) hi++;
         @(negedge clk);
         #1;
      end
      if ((rd | wr) && b0.m_read === rd && b0.m_write === wr && b0.m_addr === addr &&
          b0.m_wdata === wdata) hi++;
      mrd = {$urandom, $urandom, $urandom, $urandom};
      b0.m_rdata = mrd;
      b0.m_resp  = 1'b1;
      #1;
      ir = b0.i_resp; dr = b0.d_resp; irdata = b0.i_rdata; drdata = b0.d_rdata;
      @(negedge clk);
      b0.m_resp = 1'b0;
   endtask

   task automatic txn1(input int lat, output logic ir, output logic dr);
      @(negedge clk);
      for (int c = 0; c < lat; c++) @(negedge clk);
      b1.m_resp = 1'b1;
      #1;
      ir = b1.i_resp; dr = b1.d_resp;
      @(negedge clk);
      b1.m_resp = 1'b0;
   endtask

   initial begin
      logic         rd, wr, ir, dr;
      logic [15:0]  addr, exp_addr;
      logic [127:0] wdata, exp_wdata, irdata, drdata, mrd;
      int           hi, lat;
      bit           gd, ri, pend_i, pend_d;
      bit           exp_order [10];
      int           op, rr_i, rr_d;
      bit           rr_last_d;

      checks = 0; failures = 0;
      m_starve = 0; m_last_d = 1'b0; m_icnt = 0; m_dcnt = 0; m_perr = 1'b0;
      exp_order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
      b0.i_read = 0; b0.i_addr = 0; b0.d_read = 0; b0.d_write = 0; b0.d_addr = 0;
      b0.d_wdata = 0; b0.m_rdata = 0; b0.m_resp = 0;
      b1.i_read = 0; b1.i_addr = 0; b1.d_read = 0; b1.d_write = 0; b1.d_addr = 0;
      b1.d_wdata = 0; b1.m_rdata = 0; b1.m_resp = 0;
      rst_n = 1'b0;

      // reset values
      #2;
      check("rst_m_read", 128'(b0.m_read), 0);
      check("rst_m_write", 128'(b0.m_write), 0);
      check("rst_i_resp", 128'(b0.i_resp), 0);
      check("rst_d_resp", 128'(b0.d_resp), 0);
      check("rst_proto_err", 128'(b0.proto_err), 0);
      check("rst_m_addr", 128'(b0.m_addr), 0);
      check("rst_m_wdata", b0.m_wdata, 0);
      check("rst_i_cnt", 128'(b0.i_grant_cnt), 0);
      check("rst_d_cnt", 128'(b0.d_grant_cnt), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // lone icache read at 0x1230, memory answers after 3 wait cycles
      b0.i_read = 1'b1; b0.i_addr = 16'h1230;
      txn0(3, rd, wr, addr, wdata, hi, ir, dr, irdata, drdata, mrd);
      model_grant(1'b1, 1'b0);
      check("lone_m_read", 128'(rd), 1);
      check("lone_m_write", 128'(wr), 0);
      check("lone_m_addr", 128'(addr), 128'h1230);
      check("lone_read_cycles", 128'(hi), 4);
      check("lone_i_resp", 128'(ir), 1);
      check("lone_d_resp", 128'(dr), 0);
      check("lone_i_rdata", irdata, mrd);
      b0.i_read = 1'b0;
      #1;
      check("lone_idle_after", 128'(b0.m_read | b0.m_write), 0);
      check("lone_i_cnt", 128'(b0.i_grant_cnt), 1);

      // both requesters held continuously: dcache wins until the icache has lost 4 ties
      b0.i_read = 1'b1; b0.d_write = 1'b1;
      for (int g = 0; g < 10; g++) begin
         txn0(int'($urandom_range(0, 2)), rd, wr, addr, wdata, hi, ir, dr, irdata, drdata, mrd);
         check($sformatf("order_d_%0d", g), 128'(dr), 128'(exp_order[g]));
         check($sformatf("order_i_%0d", g), 128'(ir), 128'(!exp_order[g]));
         check($sformatf("order_wr_%0d", g), 128'(wr), 128'(exp_order[g]));
         model_grant(1'b1, exp_order[g]);
      end
      b0.i_read = 1'b0; b0.d_write = 1'b0;
      #1;
      check("order_i_cnt", 128'(b0.i_grant_cnt), 128'(m_icnt));
      check("order_d_cnt", 128'(b0.d_grant_cnt), 128'(m_dcnt));
      check("order_no_perr", 128'(b0.proto_err), 0);

      // randomized traffic against the reference model
      pend_i = 1'b0; pend_d = 1'b0;
      for (int it = 0; it < 60; it++) begin
         if (!pend_i && $urandom_range(0, 2) != 0) begin
            pend_i = 1'b1; b0.i_addr = 16'($urandom);
         end
         if (!pend_d && $urandom_range(0, 2) != 0) begin
            pend_d = 1'b1;
            op = int'($urandom_range(0, 9));
            b0.d_read  = (op < 5) || (op == 9);
            b0.d_write = (op >= 5);
            b0.d_addr  = 16'($urandom);
            b0.d_wdata = {$urandom, $urandom, $urandom, $urandom};
         end
         b0.i_read = pend_i;
         if (!pend_i && !pend_d) begin
            @(negedge clk);
            #1;
            check("rnd_quiet", 128'(b0.m_read | b0.m_write), 0);
            continue;
         end
         ri = pend_i;
         gd = model_pick_d(pend_i, pend_d);
         exp_addr  = gd ? b0.d_addr : b0.i_addr;
         exp_wdata = b0.d_wdata;
         if (gd && b0.d_read && b0.d_write) m_perr = 1'b1;
         lat = int'($urandom_range(0, 3));
         txn0(lat, rd, wr, addr, wdata, hi, ir, dr, irdata, drdata, mrd);
         check("rnd_m_write", 128'(wr), 128'(gd && b0.d_write));
         check("rnd_m_read", 128'(rd), 128'(!(gd && b0.d_write)));
         check("rnd_m_addr", 128'(addr), 128'(exp_addr));
         if (gd) check("rnd_m_wdata", wdata, exp_wdata);
         check("rnd_hold_cycles", 128'(hi), 128'(lat + 1));
         check("rnd_i_resp", 128'(ir), 128'(!gd));
         check("rnd_d_resp", 128'(dr), 128'(gd));
         check("rnd_rdata", gd ? drdata : irdata, mrd);
         model_grant(ri, gd);
         if (gd) begin
            pend_d = 1'b0; b0.d_read = 1'b0; b0.d_write = 1'b0;
         end else begin
            pend_i = 1'b0; b0.i_read = 1'b0;
         end
         #1;
         check("rnd_idle", 128'(b0.m_read | b0.m_write), 0);
         check("rnd_i_cnt", 128'(b0.i_grant_cnt), 128'(m_icnt));
         check("rnd_d_cnt", 128'(b0.d_grant_cnt), 128'(m_dcnt));
         check("rnd_perr", 128'(b0.proto_err), 128'(m_perr));
      end
      b0.i_read = 1'b0; b0.d_read = 1'b0; b0.d_write = 1'b0;
      @(negedge clk);

      // read+write together: write-back wins, error sticks; request dropped mid-transaction
      b0.d_read = 1'b1; b0.d_write = 1'b1; b0.d_addr = 16'hbeef;
      @(negedge clk);
      #1;
      check("both_m_write", 128'(b0.m_write), 1);
      check("both_m_read", 128'(b0.m_read), 0);
      check("both_perr", 128'(b0.proto_err), 1);
      b0.d_read = 1'b0; b0.d_write = 1'b0;
      @(negedge clk);
      b0.m_resp = 1'b1;
      #1;
      check("drop_d_resp", 128'(b0.d_resp), 1);
      @(negedge clk);
      b0.m_resp = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("perr_sticky", 128'(b0.proto_err), 1);

      // asynchronous reset while serving a dcache write-back
      b0.d_write = 1'b1; b0.d_addr = 16'h4444;
      @(negedge clk);
      #1;
      check("pre_rst_m_write", 128'(b0.m_write), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_m_write", 128'(b0.m_write), 0);
      check("arst_m_addr", 128'(b0.m_addr), 0);
      check("arst_i_cnt", 128'(b0.i_grant_cnt), 0);
      check("arst_d_cnt", 128'(b0.d_grant_cnt), 0);
      check("arst_perr", 128'(b0.proto_err), 0);
      b0.d_write = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      check("arst_stays_idle", 128'(b0.m_read | b0.m_write), 0);

      // round-robin instance: alternation starting with D, 2-bit counters saturate
      rr_i = 0; rr_d = 0; rr_last_d = 1'b0;
      b1.i_read = 1'b1; b1.d_read = 1'b1;
      for (int g = 0; g < 8; g++) begin
         txn1(int'($urandom_range(0, 2)), ir, dr);
         check($sformatf("rr_d_%0d", g), 128'(dr), 128'(!rr_last_d));
         check($sformatf("rr_i_%0d", g), 128'(ir), 128'(rr_last_d));
         if (rr_last_d) rr_i++; else rr_d++;
         rr_last_d = !rr_last_d;
         #1;
         check("rr_i_cnt", 128'(b1.i_grant_cnt), 128'((rr_i > 3) ? 3 : rr_i));
         check("rr_d_cnt", 128'(b1.d_grant_cnt), 128'((rr_d > 3) ? 3 : rr_d));
      end
      b1.i_read = 1'b0; b1.d_read = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
